// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector: run-time loadable pattern/length,
// selectable overlap, input-valid qualifier and a saturating match counter.
module seq_detector_prog #(
  parameter int unsigned          MAX_LEN     = 8,
  parameter logic [MAX_LEN-1:0]   DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int unsigned          DEF_LEN     = 4,
  parameter int unsigned          CNT_W       = 8,
  localparam int unsigned         LEN_W       = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cnt_clr,
  output logic               out,
  output logic               cfg_err,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               out_q, out_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_n;
  logic [LEN_W-1:0]   fill_n;
  logic               sample;
  logic               cfg_ok;
  logic               hit;

  // Select the low len_q bits of history/pattern for comparison.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
  end

  always_comb begin
    sample = !cfg_load && in_valid;
    hist_n = {hist_q[MAX_LEN-2:0], in};
    fill_n = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
    hit    = sample && (fill_n >= len_q) && (((hist_n ^ pat_q) & mask) == '0);
    cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
    out_d  = 1'b0;
    err_d  = 1'b0;
    cnt_d  = cnt_q;

    // A load outranks sampling; the bit presented alongside it is dropped.
    if (cfg_load) begin
      if (cfg_ok) begin
        pat_d  = cfg_pattern;
        len_d  = cfg_len;
        hist_d = '0;
        fill_d = '0;
      end else begin
        err_d = 1'b1;
      end
    end else if (in_valid) begin
      hist_d = hist_n;
      out_d  = hit;
      fill_d = (hit && !overlap) ? '0 : fill_n;
    end

    if (cnt_clr) begin
      cnt_d = '0;
    end else if (hit && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= LEN_W'(DEF_LEN);
      hist_q <= '0;
      fill_q <= '0;
      out_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      out_q  <= out_d;
      err_q  <= err_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out       = out_q;
  assign cfg_err   = err_q;
  assign match_cnt = cnt_q;

endmodule
